// File: rtl/adma_data_mover.sv
// ---------------------------------------------------------------------------
// adma_data_mover
//   Data-phase responder for the ADMA descriptor engine. While Permiso_Transf
//   is high it moves DAT_LEN bytes between system memory (starting at DAT_ADR)
//   and the SD card data buffer, one 32-bit word per memory beat, and raises
//   transferencia_finalizada when the descriptor's data phase is complete.
//
//   Ports
//     clk, reset_n                    clock, asynchronous active-low reset
//     Permiso_Transf                  level request from the ADMA FSM
//     Data_Transfer_Direction_Select  1 = buffer->memory, 0 = memory->buffer
//     DAT_LEN / DAT_ADR               byte count (0 = 65536) / word-aligned start
//     transferencia_finalizada        done level, held until Permiso_Transf drops
//     xfer_error                      misalignment or bus timeout, valid with done
//     mem_req/we/addr/wdata/be        memory beat request, held until mem_ack
//     mem_rdata / mem_ack             memory read data / beat complete
//     buf_rd_valid/data, buf_rd_ready card->host buffer pop
//     buf_wr_valid/data, buf_wr_ready host->card buffer push
//
//   Build option
//     ADMA_MEM_TIMEOUT_EN  when defined, a mem_ack watchdog of TIMEOUT_CYC
//                          cycles ends the transfer with xfer_error set.
// ---------------------------------------------------------------------------
module adma_data_mover #(
   parameter int unsigned ADDR_W      = 64,
   parameter int unsigned LEN_W       = 16,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              Permiso_Transf,
   input  logic              Data_Transfer_Direction_Select,
   input  logic [LEN_W-1:0]  DAT_LEN,
   input  logic [ADDR_W-1:0] DAT_ADR,
   output logic              transferencia_finalizada,
   output logic              xfer_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack,
   input  logic              buf_rd_valid,
   input  logic [31:0]       buf_rd_data,
   output logic              buf_rd_ready,
   output logic              buf_wr_valid,
   output logic [31:0]       buf_wr_data,
   input  logic              buf_wr_ready
);

   typedef enum logic [2:0] {
      IDLE, LOAD, H2C_RD, H2C_PUSH, C2H_POP, C2H_WR, DONE
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  words_q, words_d;
   logic [1:0]        rem_q, rem_d;
   logic [31:0]       data_q, data_d;
   logic              err_q, err_d;
   logic              abort_q, abort_d;
   logic              in_mem;
   logic              tmo_hit;
   logic [LEN_W-1:0]  words_new;

   assign in_mem = (state_q == H2C_RD) || (state_q == C2H_WR);

   // ceil(len/4); a zero length encodes the full 2^LEN_W bytes.
   assign words_new = (DAT_LEN == '0) ? {2'b01, {(LEN_W-2){1'b0}}}
                    : {2'b00, DAT_LEN[LEN_W-1:2]} + {{(LEN_W-1){1'b0}}, |DAT_LEN[1:0]};

`ifdef ADMA_MEM_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] tmo_q;

   // Counts cycles of an unacknowledged request; the hit fires on the
   // TIMEOUT_CYC-th such cycle so mem_req is high exactly TIMEOUT_CYC cycles.
   assign tmo_hit = in_mem && !mem_ack && (tmo_q == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         tmo_q <= '0;
      else if (in_mem && !mem_ack && !tmo_hit) tmo_q <= tmo_q + 1'b1;
      else                                  tmo_q <= '0;
   end
`else
   assign tmo_hit = 1'b0;
   // The watchdog limit has no effect in this build.
   if (TIMEOUT_CYC == 0) begin : g_tmo_unused
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         words_q <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         words_q <= words_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         err_q   <= err_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      words_d = words_q;
      rem_d   = rem_q;
      data_d  = data_q;
      err_d   = err_q;
      abort_d = abort_q;
      unique case (state_q)
         IDLE: begin
            abort_d = 1'b0;
            if (Permiso_Transf) state_d = LOAD;
         end
         LOAD: begin
            abort_d = 1'b0;
            addr_d  = DAT_ADR;
            words_d = words_new;
            rem_d   = DAT_LEN[1:0];
            err_d   = (DAT_ADR[1:0] != 2'b00);
            if (!Permiso_Transf)                 state_d = IDLE;
            else if (DAT_ADR[1:0] != 2'b00)      state_d = DONE;
            else if (Data_Transfer_Direction_Select) state_d = C2H_POP;
            else                                 state_d = H2C_RD;
         end
         // A request in flight is never withdrawn on abort; the abort is
         // remembered and honoured once the beat is acknowledged.
         H2C_RD: begin
            if (!Permiso_Transf) abort_d = 1'b1;
            if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (mem_ack) begin
               if (abort_q || !Permiso_Transf) state_d = IDLE;
               else begin
                  data_d  = mem_rdata;
                  state_d = H2C_PUSH;
               end
            end
         end
         H2C_PUSH: begin
            if (!Permiso_Transf) state_d = IDLE;
            else if (buf_wr_ready) begin
               addr_d  = addr_q + ADDR_W'(4);
               words_d = words_q - LEN_W'(1);
               state_d = (words_q == LEN_W'(1)) ? DONE : H2C_RD;
            end
         end
         C2H_POP: begin
            if (!Permiso_Transf) state_d = IDLE;
            else if (buf_rd_valid) begin
               data_d  = buf_rd_data;
               state_d = C2H_WR;
            end
         end
         C2H_WR: begin
            if (!Permiso_Transf) abort_d = 1'b1;
            if (tmo_hit) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (mem_ack) begin
               addr_d  = addr_q + ADDR_W'(4);
               words_d = words_q - LEN_W'(1);
               if (abort_q || !Permiso_Transf) state_d = IDLE;
               else state_d = (words_q == LEN_W'(1)) ? DONE : C2H_POP;
            end
         end
         DONE: begin
            if (!Permiso_Transf) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decode only registered state, so they are glitch-free beat to
   // beat and all drop together on an asynchronous reset.
   assign transferencia_finalizada = (state_q == DONE);
   assign xfer_error   = (state_q == DONE) && err_q;
   assign mem_req      = in_mem;
   assign mem_we       = (state_q == C2H_WR);
   assign mem_addr     = addr_q;
   assign mem_wdata    = data_q;
   assign buf_rd_ready = (state_q == C2H_POP);
   assign buf_wr_valid = (state_q == H2C_PUSH);
   assign buf_wr_data  = data_q;

   always_comb begin
      mem_be = '0;
      if (in_mem) begin
         mem_be = 4'b1111;
         if ((state_q == C2H_WR) && (words_q == LEN_W'(1))) begin
            unique case (rem_q)
               2'd1:    mem_be = 4'b0001;
               2'd2:    mem_be = 4'b0011;
               2'd3:    mem_be = 4'b0111;
               default: mem_be = 4'b1111;
            endcase
         end
      end
   end

endmodule
